// File: rtl/mini_riscv_pkg.sv
// ---------------------------------------------------------------------------
// mini_riscv_pkg
// Shared types and constants for the Mini-RISC-V control-flow blocks.
//   XLEN          : architectural register / PC width
//   INSN_BYTES    : size of one instruction, used for link address math
//   brctl_state_t : sequencing states of the branch redirect controller
// ---------------------------------------------------------------------------
package mini_riscv_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  // IDLE      : watching decode for control-flow events
  // WAIT_OPND : jalr seen, waiting for its base register to be forwarded
  // REDIRECT  : offering the new PC to fetch
  // FLUSH     : squashing the wrong-path instructions behind the redirect
  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    REDIRECT,
    FLUSH
  } brctl_state_t;

endpackage

// File: rtl/brctl_target_calc.sv
// ---------------------------------------------------------------------------
// brctl_target_calc
// Purely combinational redirect target arithmetic.
// Ports:
//   pc_dec_i      : PC of the decoded instruction
//   off_sext_i    : sign-extended branch/jal offset or jalr immediate
//   rs1_val_i     : forwarded rs1 value (jalr base)
//   use_rs1_i     : 1 selects the jalr form (rs1 + imm, bit 0 cleared)
//   target_o      : computed redirect target
//   link_addr_o   : return address, pc_dec_i + instruction size
//   misaligned_o  : target is not on a 4-byte boundary (bit 1 set)
// ---------------------------------------------------------------------------
module brctl_target_calc
  import mini_riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_dec_i,
  input  logic [XLEN-1:0] off_sext_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic            use_rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_addr_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] baseSel;
  logic [XLEN-1:0] sumRaw;

  // Pick the base (PC-relative or register-relative), add the offset with
  // natural mod-2^XLEN wrap, and clear bit 0 for the jalr form only.
  always_comb begin
    baseSel = use_rs1_i ? rs1_val_i : pc_dec_i;
    sumRaw  = baseSel + off_sext_i;
    if (use_rs1_i) begin
      target_o = {sumRaw[XLEN-1:1], 1'b0};
    end else begin
      target_o = sumRaw;
    end
  end

  // The return address is always relative to the decoded instruction.
  assign link_addr_o = pc_dec_i + XLEN'(INSN_BYTES);

  // Bit 0 is either cleared (jalr) or legitimately odd offsets are not
  // checked; only bit 1 indicates a non-word-aligned fetch target.
  assign misaligned_o = target_o[1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
// Sequences control-flow changes for the Mini-RISC-V pipeline: computes the
// branch/jal/jalr target, hands it to fetch, then holds a counted flush.
// Optional feature macro: MISALIGN_TRAP_EN (adds misalign_trap output and
// turns misaligned targets into a trap + flush instead of a redirect).
// Parameters:
//   FLUSH_CYCLES : cycles flush stays high after fetch accepts (1-15)
//   CNT_W        : width of the completed-redirect counter
// Ports:
//   clk, Rst                       : clock, synchronous active-high reset
//   dec_valid, branch, jal, jalr   : decoded instruction qualifiers
//   brn_taken                      : branch condition result
//   pc_dec, off_sext, rs1_val      : target operands
//   rs1_ready                      : rs1_val is hazard-free
//   fetch_ready                    : fetch accepts the redirect
//   redirect_valid, redirect_pc    : redirect handshake to fetch
//   flush, stall                   : pipeline squash / hold controls
//   link_we, link_addr             : link register write pulse and value
//   redirect_cnt                   : completed redirect count
//   misalign_trap (macro only)     : one-cycle misaligned-target trap pulse
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
  import mini_riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
)
(
  input  logic             clk,
  input  logic             Rst,
  input  logic             dec_valid,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             brn_taken,
  input  logic [31:0]      pc_dec,
  input  logic [31:0]      off_sext,
  input  logic [31:0]      rs1_val,
  input  logic             rs1_ready,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic             link_we,
  output logic [31:0]      link_addr,
  output logic [CNT_W-1:0] redirect_cnt
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap
`endif
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  brctl_state_t    state_q;
  logic [3:0]      flushCnt_q;
  logic            redirectValid_q;
  logic            flush_q;
  logic            linkWe_q;
  logic            misalignTrap_q;
  logic [31:0]     redirectPc_q;
  logic [31:0]     linkAddr_q;
  logic [CNT_W-1:0] redirectCnt_q;

  logic            selJal;
  logic            selJalr;
  logic            selBranch;
  logic            idleEvent;
  logic            idleWait;
  logic            accept_d;
  logic            linkPulse_d;
  logic            useRs1;
  logic            trap_d;
  logic [31:0]     target_d;
  logic [31:0]     linkAddr_d;
  logic            misaligned;

  // Priority among simultaneously set decode bits is jal > jalr > branch,
  // so each select is masked by every higher-priority bit.
  always_comb begin
    selJal    = jal;
    selJalr   = !jal && jalr;
    selBranch = !jal && !jalr && branch;
    idleEvent = dec_valid && (selJal || (selJalr && rs1_ready) ||
                              (selBranch && brn_taken));
    idleWait  = dec_valid && selJalr && !rs1_ready;
  end

  // An event is taken either straight from IDLE or when a parked jalr finally
  // sees its operand. Decode is held during WAIT_OPND, so the live inputs are
  // still the jalr's own operands and can feed the adder directly.
  always_comb begin
    accept_d    = ((state_q == IDLE) && idleEvent) ||
                  ((state_q == WAIT_OPND) && rs1_ready);
    linkPulse_d = (state_q == WAIT_OPND) || selJal || selJalr;
    useRs1      = (state_q == WAIT_OPND) || selJalr;
  end

  brctl_target_calc u_target_calc (
    .pc_dec_i     (pc_dec),
    .off_sext_i   (off_sext),
    .rs1_val_i    (rs1_val),
    .use_rs1_i    (useRs1),
    .target_o     (target_d),
    .link_addr_o  (linkAddr_d),
    .misaligned_o (misaligned)
  );

`ifdef MISALIGN_TRAP_EN
  // A misaligned target becomes a trap instead of a redirect.
  assign trap_d = misaligned;
`else
  // Without the trap feature misaligned targets redirect like any other.
  logic unusedMisalign;
  assign trap_d         = 1'b0;
  assign unusedMisalign = misaligned ^ misalignTrap_q;
`endif

  // Stall is the only combinational output: a jalr with an unready operand
  // must hold decode in the very cycle it is seen, before any state change.
  always_comb begin
    stall = (state_q == WAIT_OPND) || (state_q == REDIRECT) ||
            ((state_q == IDLE) && idleWait);
  end

  // Single sequencing process: state, registered outputs and both counters.
  // Anything decode presents outside IDLE is ignored (held upstream while
  // stalled, squashed while flushing).
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q         <= IDLE;
      flushCnt_q      <= '0;
      redirectValid_q <= 1'b0;
      flush_q         <= 1'b0;
      linkWe_q        <= 1'b0;
      misalignTrap_q  <= 1'b0;
      redirectPc_q    <= '0;
      linkAddr_q      <= '0;
      redirectCnt_q   <= '0;
    end else begin
      linkWe_q       <= 1'b0;
      misalignTrap_q <= 1'b0;
      case (state_q)
        IDLE, WAIT_OPND: begin
          if (accept_d) begin
            redirectPc_q <= target_d;
            linkAddr_q   <= linkAddr_d;
            if (trap_d) begin
              misalignTrap_q <= 1'b1;
              flush_q        <= 1'b1;
              flushCnt_q     <= FLUSH_LAST;
              state_q        <= FLUSH;
            end else begin
              linkWe_q        <= linkPulse_d;
              redirectValid_q <= 1'b1;
              state_q         <= REDIRECT;
            end
          end else if ((state_q == IDLE) && idleWait) begin
            state_q <= WAIT_OPND;
          end
        end
        REDIRECT: begin
          if (fetch_ready) begin
            redirectValid_q <= 1'b0;
            redirectCnt_q   <= redirectCnt_q + CNT_W'(1);
            flush_q         <= 1'b1;
            flushCnt_q      <= FLUSH_LAST;
            state_q         <= FLUSH;
          end
        end
        FLUSH: begin
          if (flushCnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            flushCnt_q <= flushCnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign redirect_valid = redirectValid_q;
  assign redirect_pc    = redirectPc_q;
  assign flush          = flush_q;
  assign link_we        = linkWe_q;
  assign link_addr      = linkAddr_q;
  assign redirect_cnt   = redirectCnt_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_trap  = misalignTrap_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Self-checking bench for branch_redirect_ctrl. Each transaction is predicted
// from the instruction semantics (target arithmetic, how long each phase
// should last, how many pulses should appear) and compared with what the
// design produces. Works with or without MISALIGN_TRAP_EN defined.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             Rst;
  logic             dec_valid, branch, jal, jalr, brn_taken;
  logic [31:0]      pc_dec, off_sext, rs1_val;
  logic             rs1_ready, fetch_ready;
  logic             redirect_valid, flush, stall, link_we;
  logic [31:0]      redirect_pc, link_addr;
  logic [CNT_W-1:0] redirect_cnt;
`ifdef MISALIGN_TRAP_EN
  logic             misalign_trap;
`endif

  int compared   = 0;
  int mismatched = 0;
  int modelCnt   = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .Rst            (Rst),
    .dec_valid      (dec_valid),
    .branch         (branch),
    .jal            (jal),
    .jalr           (jalr),
    .brn_taken      (brn_taken),
    .pc_dec         (pc_dec),
    .off_sext       (off_sext),
    .rs1_val        (rs1_val),
    .rs1_ready      (rs1_ready),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .redirect_cnt   (redirect_cnt)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap)
`endif
  );

  // Global safety net in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic trapOut();
`ifdef MISALIGN_TRAP_EN
    return misalign_trap;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idleInputs();
    dec_valid   = 1'b0;
    branch      = 1'b0;
    jal         = 1'b0;
    jalr        = 1'b0;
    brn_taken   = 1'b0;
    pc_dec      = '0;
    off_sext    = '0;
    rs1_val     = '0;
    rs1_ready   = 1'b0;
    fetch_ready = 1'b0;
  endtask

  // Everything must read zero one edge after reset, counter included.
  task automatic test_reset();
    Rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({redirect_valid, flush, stall, link_we, trapOut()} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000",
               {redirect_valid, flush, stall, link_we, trapOut()});
    end
    compared++;
    if ({redirect_pc, link_addr} !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got pc=%h link=%h want 0/0", redirect_pc, link_addr);
    end
    compared++;
    if (redirect_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_cnt: got %0d want 0", redirect_cnt);
    end
    Rst = 1'b0;
    modelCnt = 0;
  endtask

  // Taken branch with fetch ready immediately, checked edge by edge.
  task automatic test_branch_taken();
    dec_valid = 1'b1; branch = 1'b1; brn_taken = 1'b1;
    pc_dec = 32'h100; off_sext = 32'hFFFF_FFF0; fetch_ready = 1'b1;
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL br_event_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    dec_valid = 1'b0; branch = 1'b0; brn_taken = 1'b0;
    compared++;
    if ({redirect_valid, link_we, stall} !== 3'b101 || redirect_pc !== 32'h0F0) begin
      mismatched++;
      $display("[TB] FAIL br_redirect: got rv/lwe/stall=%b pc=%h want 101 pc=000000f0",
               {redirect_valid, link_we, stall}, redirect_pc);
    end
    @(posedge clk); #1;
    compared++;
    if ({redirect_valid, flush, stall, link_we} !== 4'b0100 ||
        redirect_cnt !== CNT_W'(modelCnt + 1)) begin
      mismatched++;
      $display("[TB] FAIL br_flush1: got rv/fl/st/lwe=%b cnt=%0d want 0100 cnt=%0d",
               {redirect_valid, flush, stall, link_we}, redirect_cnt, modelCnt + 1);
    end
    @(posedge clk); #1;
    compared++;
    if (flush !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL br_flush2: got %b want 1", flush);
    end
    @(posedge clk); #1;
    compared++;
    if (flush !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL br_flush_end: got %b want 0", flush);
    end
    modelCnt++;
    idleInputs();
  endtask

  // One instruction from issue to return-to-idle. The expectation is derived
  // from the ISA rules: which bit wins, what the target is, how many cycles
  // decode is held (operand wait + fetch wait), how long the flush lasts.
  // A taken jal with random operands is presented during the flush and must
  // have no effect.
  task automatic runTxn(input string name, input logic jB, input logic jrB,
                        input logic bB, input logic tB, input logic [31:0] pcV,
                        input logic [31:0] offV, input logic [31:0] rs1V,
                        input int k, input int fd);
    logic        selJalr;
    logic        taken;
    logic        trap;
    logic        isLink;
    logic [31:0] tgt;
    int          kEff, expStall, expRv;
    int          stallCnt, linkCnt, rvCnt, flushCnt, trapCnt, trapAt;
    bit          done, sawFlush, pcOk, laOk;
    stallCnt = 0; linkCnt = 0; rvCnt = 0; flushCnt = 0; trapCnt = 0; trapAt = -1;
    done = 0; sawFlush = 0; pcOk = 1; laOk = 1;

    selJalr = !jB && jrB;
    taken   = jB || jrB || (bB && tB);
    tgt     = selJalr ? ((rs1V + offV) & 32'hFFFF_FFFE) : (pcV + offV);
    trap    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap    = taken && tgt[1];
`endif
    isLink   = (jB || jrB) && !trap;
    kEff     = selJalr ? k : 0;
    expRv    = (taken && !trap) ? fd + 1 : 0;
    expStall = taken ? (((kEff > 0) ? kEff + 1 : 0) + expRv) : 0;

    for (int c = 0; c < 80 && !done; c++) begin
      rs1_ready = (c >= kEff);
      if (c == 0 || (selJalr && c <= kEff)) begin
        dec_valid = 1'b1; jal = jB; jalr = jrB; branch = bB; brn_taken = tB;
        pc_dec = pcV; off_sext = offV; rs1_val = rs1V;
      end else if (flush) begin
        dec_valid = 1'b1; jal = 1'b1; jalr = 1'b0; branch = 1'b0; brn_taken = 1'b1;
        pc_dec = $urandom; off_sext = $urandom; rs1_val = $urandom; rs1_ready = 1'b1;
      end else begin
        dec_valid = 1'b0; jal = 1'b0; jalr = 1'b0; branch = 1'b0; brn_taken = 1'b0;
      end
      fetch_ready = redirect_valid && (rvCnt > fd);
      #1;
      if (stall) stallCnt++;
      @(posedge clk); #1;
      if (link_we) begin
        linkCnt++;
        if (link_addr !== pcV + 32'd4) laOk = 0;
      end
      if (redirect_valid) begin
        rvCnt++;
        if (redirect_pc !== tgt) pcOk = 0;
      end
      if (flush) begin
        flushCnt++;
        sawFlush = 1;
      end
      if (trapOut()) begin
        trapCnt++;
        if (trapAt < 0) trapAt = c;
      end
      if (sawFlush && !flush) done = 1;
      if (!taken && c >= 1) done = 1;
    end
    idleInputs();
    if (taken && !trap) modelCnt++;

    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no return to idle want idle within 80 cycles", name);
    end
    compared++;
    if (stallCnt != expStall) begin
      mismatched++;
      $display("[TB] FAIL %s_stall: got %0d cycles want %0d", name, stallCnt, expStall);
    end
    compared++;
    if (rvCnt != expRv || !pcOk) begin
      mismatched++;
      $display("[TB] FAIL %s_redirect: got %0d cycles pcOk=%0d want %0d cycles pc=%h",
               name, rvCnt, pcOk, expRv, tgt);
    end
    compared++;
    if (linkCnt != int'(isLink) || !laOk) begin
      mismatched++;
      $display("[TB] FAIL %s_link: got %0d pulses addrOk=%0d want %0d pulses addr=%h",
               name, linkCnt, laOk, isLink, pcV + 32'd4);
    end
    compared++;
    if (flushCnt != (taken ? FLUSH_CYCLES : 0)) begin
      mismatched++;
      $display("[TB] FAIL %s_flush: got %0d cycles want %0d", name, flushCnt,
               taken ? FLUSH_CYCLES : 0);
    end
    compared++;
    if (trapCnt != int'(trap) || (trap && trapAt != kEff)) begin
      mismatched++;
      $display("[TB] FAIL %s_trap: got %0d pulses at %0d want %0d at %0d",
               name, trapCnt, trapAt, trap, kEff);
    end
    compared++;
    if (redirect_cnt !== CNT_W'(modelCnt)) begin
      mismatched++;
      $display("[TB] FAIL %s_cnt: got %0d want %0d", name, redirect_cnt, modelCnt);
    end
    if (taken) begin
      compared++;
      if (link_addr !== pcV + 32'd4) begin
        mismatched++;
        $display("[TB] FAIL %s_link_hold: got %h want %h", name, link_addr, pcV + 32'd4);
      end
    end
  endtask

  task automatic test_jal();
    runTxn("jal", 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0, 0, 3);
  endtask

  task automatic test_jalr_wait();
    runTxn("jalr_wait", 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h4, 32'h1001, 2, 0);
  endtask

  task automatic test_back_to_back();
    runTxn("not_taken", 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h80, 32'h0, 0, 0);
    runTxn("taken_b2b", 1'b0, 1'b0, 1'b1, 1'b1, 32'h504, 32'h80, 32'h0, 0, 0);
    runTxn("priority", 1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 32'h10, 32'h7000, 1, 1);
  endtask

  task automatic test_misalign();
    runTxn("misalign_jal", 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h2, 32'h0, 0, 0);
  endtask

  // Reset while redirect is pending and while flushing: next edge all zero,
  // and nothing residual afterwards.
  task automatic test_reset_mid();
    dec_valid = 1'b1; jal = 1'b1; pc_dec = 32'h300; off_sext = 32'h10;
    @(posedge clk); #1;
    idleInputs();
    compared++;
    if (redirect_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstmid_pre: got %b want 1", redirect_valid);
    end
    Rst = 1'b1;
    @(posedge clk); #1;
    Rst = 1'b0;
    modelCnt = 0;
    compared++;
    if ({redirect_valid, flush, stall, link_we, trapOut()} !== 5'b0 ||
        {redirect_pc, link_addr} !== 64'h0 || redirect_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_redirect: got ctl=%b pc=%h link=%h cnt=%0d want all 0",
               {redirect_valid, flush, stall, link_we, trapOut()}, redirect_pc, link_addr,
               redirect_cnt);
    end
    dec_valid = 1'b1; branch = 1'b1; brn_taken = 1'b1;
    pc_dec = 32'h800; off_sext = 32'h20; fetch_ready = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    compared++;
    if (flush !== 1'b1 || redirect_cnt !== CNT_W'(1)) begin
      mismatched++;
      $display("[TB] FAIL rstmid_pre_flush: got flush=%b cnt=%0d want 1/1", flush, redirect_cnt);
    end
    Rst = 1'b1;
    @(posedge clk); #1;
    Rst = 1'b0;
    modelCnt = 0;
    compared++;
    if ({redirect_valid, flush, stall, link_we, trapOut()} !== 5'b0 ||
        {redirect_pc, link_addr} !== 64'h0 || redirect_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_flush: got ctl=%b pc=%h link=%h cnt=%0d want all 0",
               {redirect_valid, flush, stall, link_we, trapOut()}, redirect_pc, link_addr,
               redirect_cnt);
    end
    @(posedge clk); #1;
    compared++;
    if ({redirect_valid, flush, stall, link_we, trapOut()} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_residual: got %b want 00000",
               {redirect_valid, flush, stall, link_we, trapOut()});
    end
  endtask

  // Randomized mix of every instruction flavour with random operand and
  // fetch latencies.
  task automatic test_random();
    logic jB, jrB, bB, tB;
    for (int i = 0; i < 40; i++) begin
      jB = 1'b0; jrB = 1'b0; bB = 1'b0; tB = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: begin bB = 1'b1; tB = 1'b1; end
        1: begin bB = 1'b1; tB = 1'b0; end
        2: jB = 1'b1;
        3: jrB = 1'b1;
        4: ;
        default: begin
          jB = $urandom_range(0, 1); jrB = $urandom_range(0, 1); bB = $urandom_range(0, 1);
        end
      endcase
      runTxn($sformatf("rand%0d", i), jB, jrB, bB, tB, $urandom & 32'hFFFF_FFFC,
             $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  // Directed scenarios first, then the random soak, then the summary.
  initial begin
    test_reset();
    test_branch_taken();
    test_jal();
    test_jalr_wait();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow changes for the Mini-RISC-V pipeline.
- Accepts decoded branch/jal/jalr events plus the offset produced by the decoder's branch-offset logic, and computes the redirect target.
- Handshakes the target into fetch and drives a counted pipeline flush.
- Stalls decode while a jalr base operand is not ready or a redirect is in progress.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held high after fetch accepts a redirect (range 1-15).
- CNT_W, 16, width of the taken-redirect performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode holds a valid instruction this cycle.
- branch  in  1  conditional branch decoded.
- jal  in  1  jal decoded.
- jalr  in  1  jalr decoded.
- brn_taken  in  1  branch condition result, valid with dec_valid.
- pc_dec  in  32  PC of the decoded instruction.
- off_sext  in  32  sign-extended branch/jal offset, or jalr immediate.
- rs1_val  in  32  forwarded rs1 value.
- rs1_ready  in  1  rs1_val is hazard-free this cycle.
- fetch_ready  in  1  fetch accepts the redirect.
- redirect_valid  out  1  target is valid, held until fetch_ready.
- redirect_pc  out  32  redirect target.
- flush  out  1  squash IF/ID contents.
- stall  out  1  hold PC and IF/ID.
- link_we  out  1  one-cycle pulse: write link_addr to rd.
- link_addr  out  32  pc_dec + 4.
- redirect_cnt  out  CNT_W  count of completed redirects.

Behaviour:
- Reset (sync, Rst=1 at a clk edge): state=IDLE; all outputs 0, including redirect_pc, link_addr and redirect_cnt. Reset asserted mid-operation aborts the redirect or flush immediately, with no residual pulses.
- States:
  - IDLE: stall=0.
  - An event is dec_valid & ((branch & brn_taken) | jal | (jalr & rs1_ready)).
    - jal/branch target = pc_dec + off_sext (32-bit, wraps mod 2^32).
    - jalr target = (rs1_val + off_sext) & ~1.
  - On an event, the target, link_addr and (for jal/jalr) a link_we pulse are registered. Next state is REDIRECT, so redirect_valid rises 1 cycle after the event.
  - dec_valid & jalr & !rs1_ready -> WAIT_OPND, with stall=1 combinationally in that same cycle.
  - Not-taken branch or non-control instruction: no action, stall=0.
  - WAIT_OPND: stall=1.
    - When rs1_ready=1, compute the jalr target from the current rs1_val/off_sext (decode is held, so its inputs are stable), pulse link_we, go to REDIRECT.
    - There is no timeout.
  - REDIRECT: redirect_valid=1 and stall=1. redirect_pc is stable while waiting.
    - On fetch_ready=1: redirect_cnt increments (wraps at 2^CNT_W), then go to FLUSH with counter=FLUSH_CYCLES-1.
    - fetch_ready arriving on the same cycle redirect_valid rises is accepted; minimum REDIRECT occupancy is 1 cycle.
  - FLUSH: flush=1 and stall=0 (fetch runs from the new PC). The counter decrements each cycle; at 0, return to IDLE.
    - dec_valid is ignored while flush=1.
  - Events arriving while state != IDLE are ignored; upstream holds them because stall=1. FLUSH is the exception: its inputs are squashed.
- link_we is high exactly 1 cycle per jal/jalr and never for branches. link_addr is held until the next event.
- Multiple control decode bits set together: priority jal > jalr > branch.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: adds output port misalign_trap (1 bit, reset 0).
  - If the computed target has bit[1] != 0, the block raises misalign_trap as a 1-cycle pulse 1 cycle after the event.
  - In that case it suppresses link_we, redirect_valid and the counter increment, and goes directly to FLUSH.
- Undefined: no port; misaligned targets redirect normally.

Decomposition:
- Shared package (mini_riscv_pkg): brctl_state_t enum {IDLE, WAIT_OPND, REDIRECT, FLUSH}, XLEN=32, INSN_BYTES=4.
- One sub-module: brctl_target_calc, purely combinational. It performs target select/add, jalr LSB clear, link_addr = pc_dec + 4 and the misalign check. The FSM, registers and counters stay in the top.

Test Plan:
- Taken branch, pc_dec=0x100, off_sext=0xFFFFFFF0, fetch_ready=1:
  - redirect_valid=1 with redirect_pc=0x0F0 on cycle+1.
  - flush=1 for 2 cycles.
  - link_we never asserted.
  - redirect_cnt=1.
- jal, pc_dec=0x200, off=0x40, fetch_ready low for 3 cycles:
  - redirect_pc=0x240 held with stall=1 for 4 cycles.
  - link_we pulse with link_addr=0x204.
- jalr, rs1_ready=0 for 2 cycles then rs1_val=0x1001, off=0x4:
  - stall=1 throughout.
  - redirect_pc=0x1004.
- Not-taken branch followed by back-to-back taken branch during FLUSH:
  - No stall or redirect for the not-taken branch.
  - The branch during FLUSH is ignored; redirect_cnt increments once.
- Rst asserted during REDIRECT and during FLUSH:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - redirect_cnt=0.
- MISALIGN_TRAP_EN defined, jal to 0x202:
  - misalign_trap pulse on cycle+1.
  - No redirect_valid, no link_we, flush=1 for 2 cycles.
